// File: rtl/eth_phy_10g_rx_lock_mon.sv
// 10GBASE-R receive sync-header monitor: block lock via SERDES bitslip, 125 us BER window, link status.
// All outputs registered; a header sampled on an edge is reflected right after that edge, rx_status one edge later.
module eth_phy_10g_rx_lock_mon #(
   parameter int BITSLIP_HIGH_CYCLES = 1,
   parameter int BITSLIP_LOW_CYCLES  = 8,
   parameter int COUNT_125US         = 19531
) (
   input  logic       rx_clk,
   input  logic       rx_rst_n,
   input  logic [1:0] serdes_rx_hdr,
   output logic       serdes_rx_bitslip,
   output logic       rx_block_lock,
   output logic       rx_high_ber,
   output logic       rx_status,
   output logic [3:0] rx_sh_invalid_count
);

   localparam int SLIP_MAX = (BITSLIP_HIGH_CYCLES - 1 > BITSLIP_LOW_CYCLES) ?
                             (BITSLIP_HIGH_CYCLES - 1) : BITSLIP_LOW_CYCLES;
   localparam int SLIP_W   = (SLIP_MAX < 1) ? 1 : $clog2(SLIP_MAX + 1);
   localparam int TIME_W   = $clog2(COUNT_125US + 1);

   localparam logic [SLIP_W-1:0] SLIP_HIGH_LD = SLIP_W'(BITSLIP_HIGH_CYCLES - 1);
   localparam logic [SLIP_W-1:0] SLIP_LOW_LD  = SLIP_W'(BITSLIP_LOW_CYCLES);
   localparam logic [TIME_W-1:0] TIME_LD      = TIME_W'(COUNT_125US);

   logic              hdr_valid;
   logic [5:0]        sh_cnt_q, sh_cnt_d;
   logic [3:0]        inv_cnt_q, inv_cnt_d;
   logic              lock_q, lock_d;
   logic              slip_q, slip_d;
   logic [SLIP_W-1:0] slip_cnt_q, slip_cnt_d;
   logic [TIME_W-1:0] time_q, time_d;
   logic [3:0]        ber_cnt_q, ber_cnt_d;
   logic              high_ber_q, high_ber_d;
   logic              status_q, status_d;

   assign hdr_valid = serdes_rx_hdr[1] ^ serdes_rx_hdr[0];

   // Frame sync: slip hold-off first, then header evaluation.
   always_comb begin
      sh_cnt_d   = sh_cnt_q;
      inv_cnt_d  = inv_cnt_q;
      lock_d     = lock_q;
      slip_d     = slip_q;
      slip_cnt_d = slip_cnt_q;
      if (slip_cnt_q != '0) begin
         slip_cnt_d = slip_cnt_q - 1'b1;
      end else if (slip_q) begin
         slip_d     = 1'b0;
         slip_cnt_d = SLIP_LOW_LD;
      end else if (hdr_valid) begin
         sh_cnt_d = sh_cnt_q + 6'd1;
         if (sh_cnt_q == 6'd63) begin
            sh_cnt_d  = '0;
            inv_cnt_d = '0;
            if (inv_cnt_q == 4'd0) begin
               lock_d = 1'b1;
            end
         end
      end else begin
         sh_cnt_d  = sh_cnt_q + 6'd1;
         inv_cnt_d = inv_cnt_q + 4'd1;
         if (!lock_q || inv_cnt_q == 4'd15) begin
            sh_cnt_d   = '0;
            inv_cnt_d  = '0;
            lock_d     = 1'b0;
            slip_d     = 1'b1;
            slip_cnt_d = SLIP_HIGH_LD;
         end else if (sh_cnt_q == 6'd63) begin
            sh_cnt_d  = '0;
            inv_cnt_d = '0;
         end
      end
   end

   // BER window runs regardless of lock or slip hold-off.
   always_comb begin
      time_d     = (time_q != '0) ? (time_q - 1'b1) : time_q;
      ber_cnt_d  = ber_cnt_q;
      high_ber_d = high_ber_q;
      if (!hdr_valid) begin
         if (ber_cnt_q == 4'd15) begin
            high_ber_d = 1'b1;
         end else begin
            ber_cnt_d = ber_cnt_q + 4'd1;
            if (ber_cnt_q == 4'd14) begin
               high_ber_d = 1'b1;
            end
         end
      end
      if (time_q == '0) begin
         time_d    = TIME_LD;
         ber_cnt_d = '0;
         if (ber_cnt_q != 4'd15 && hdr_valid) begin
            high_ber_d = 1'b0;
         end
      end
      status_d = lock_q & ~high_ber_q;
   end

   always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
         sh_cnt_q   <= '0;
         inv_cnt_q  <= '0;
         lock_q     <= 1'b0;
         slip_q     <= 1'b0;
         slip_cnt_q <= '0;
         time_q     <= TIME_LD;
         ber_cnt_q  <= '0;
         high_ber_q <= 1'b0;
         status_q   <= 1'b0;
      end else begin
         sh_cnt_q   <= sh_cnt_d;
         inv_cnt_q  <= inv_cnt_d;
         lock_q     <= lock_d;
         slip_q     <= slip_d;
         slip_cnt_q <= slip_cnt_d;
         time_q     <= time_d;
         ber_cnt_q  <= ber_cnt_d;
         high_ber_q <= high_ber_d;
         status_q   <= status_d;
      end
   end

   assign serdes_rx_bitslip   = slip_q;
   assign rx_block_lock       = lock_q;
   assign rx_high_ber         = high_ber_q;
   assign rx_status           = status_q;
   assign rx_sh_invalid_count = inv_cnt_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_lock_mon.sv
// Directed bench for eth_phy_10g_rx_lock_mon; cycle N is the N-th rising edge after reset release.
module tb_eth_phy_10g_rx_lock_mon;

   localparam int S_LOCK = 0, S_BER = 1, S_STAT = 2, S_SLIP = 3, S_INV = 4;

   logic       rx_clk = 1'b0;
   logic       rx_rst_n = 1'b0;
   logic [1:0] serdes_rx_hdr = 2'b01;
   logic       serdes_rx_bitslip;
   logic       rx_block_lock;
   logic       rx_high_ber;
   logic       rx_status;
   logic [3:0] rx_sh_invalid_count;

   eth_phy_10g_rx_lock_mon #(
      .BITSLIP_HIGH_CYCLES(1),
      .BITSLIP_LOW_CYCLES (8),
      .COUNT_125US        (125)
   ) dut (
      .rx_clk             (rx_clk),
      .rx_rst_n           (rx_rst_n),
      .serdes_rx_hdr      (serdes_rx_hdr),
      .serdes_rx_bitslip  (serdes_rx_bitslip),
      .rx_block_lock      (rx_block_lock),
      .rx_high_ber        (rx_high_ber),
      .rx_status          (rx_status),
      .rx_sh_invalid_count(rx_sh_invalid_count)
   );

   always #5 rx_clk = ~rx_clk;

   typedef struct {
      int    cyc;
      int    sig;
      int    val;
      string name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   dcyc = 0;

   always @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) cyc <= 0;
      else           cyc <= cyc + 1;
   end

   function automatic int sample(int sig);
      case (sig)
         S_LOCK:  return int'(rx_block_lock);
         S_BER:   return int'(rx_high_ber);
         S_STAT:  return int'(rx_status);
         S_SLIP:  return int'(serdes_rx_bitslip);
         S_INV:   return int'(rx_sh_invalid_count);
         default: return -1;
      endcase
   endfunction

   // Monitor: compares queued expectations against the DUT at the falling edge of their cycle.
   initial begin
      exp_t e;
      int   act;
      forever begin
         @(negedge rx_clk);
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = sample(e.sig);
            checks++;
            if (e.cyc != cyc) begin
               errors++;
               $display("FAIL %s: due at cycle %0d, reached at cycle %0d", e.name, e.cyc, cyc);
            end else if (act != e.val) begin
               errors++;
               $display("FAIL %s @cycle %0d: got %0d, expected %0d", e.name, cyc, act, e.val);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   task automatic expect_now(int sig, int val, string name);
      exp_t e;
      e.cyc  = dcyc;
      e.sig  = sig;
      e.val  = val;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic send(logic [1:0] h, int n);
      repeat (n) begin
         serdes_rx_hdr = h;
         @(posedge rx_clk);
         #1;
         dcyc++;
      end
   endtask

   task automatic send_to(logic [1:0] h, int c);
      if (c > dcyc) send(h, c - dcyc);
   endtask

   task automatic drain();
      @(negedge rx_clk);
      #1;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations never reached, expected 0", sb.size());
         sb.delete();
      end
   endtask

   // Reset lands mid-cycle so the cleared state is observed before any clock edge.
   task automatic reset_dut();
      @(posedge rx_clk);
      #1;
      rx_rst_n      = 1'b0;
      serdes_rx_hdr = 2'b01;
      dcyc          = 0;
      expect_now(S_LOCK, 0, "rst_lock");
      expect_now(S_BER,  0, "rst_ber");
      expect_now(S_STAT, 0, "rst_status");
      expect_now(S_SLIP, 0, "rst_bitslip");
      expect_now(S_INV,  0, "rst_inv");
      repeat (2) @(posedge rx_clk);
      #2;
      rx_rst_n = 1'b1;
   endtask

   initial begin
      // Continuous valid headers: lock after the 64th, status one cycle later, no slip.
      reset_dut();
      for (int k = 1; k <= 63; k++) begin
         send(2'b01, 1);
         expect_now(S_SLIP, 0, "t1_no_slip");
      end
      expect_now(S_LOCK, 0, "t1_lock_63");
      expect_now(S_STAT, 0, "t1_status_63");
      send_to(2'b01, 64);
      expect_now(S_LOCK, 1, "t1_lock_64");
      expect_now(S_STAT, 0, "t1_status_64");
      send_to(2'b01, 65);
      expect_now(S_STAT, 1, "t1_status_65");
      expect_now(S_SLIP, 0, "t1_no_slip_65");
      drain();

      // Locked, 15 invalid headers: lock held, BER high until a clean window ends (windows end at 126, 252).
      reset_dut();
      send_to(2'b01, 64);
      expect_now(S_LOCK, 1, "t3_lock");
      send_to(2'b00, 78);
      expect_now(S_INV, 14, "t3_inv_78");
      expect_now(S_BER,  0, "t3_ber_78");
      send_to(2'b00, 79);
      expect_now(S_INV, 15, "t3_inv_79");
      expect_now(S_LOCK, 1, "t3_lock_79");
      expect_now(S_BER,  1, "t3_ber_79");
      expect_now(S_STAT, 1, "t3_status_79");
      send_to(2'b01, 80);
      expect_now(S_STAT, 0, "t3_status_80");
      expect_now(S_INV, 15, "t3_inv_80");
      send_to(2'b01, 126);
      expect_now(S_BER, 1, "t3_ber_win1_end");
      send_to(2'b01, 127);
      expect_now(S_INV, 15, "t3_inv_127");
      send_to(2'b01, 128);
      expect_now(S_INV, 0, "t3_inv_cleared");
      expect_now(S_LOCK, 1, "t3_lock_128");
      send_to(2'b01, 251);
      expect_now(S_BER, 1, "t3_ber_251");
      send_to(2'b01, 252);
      expect_now(S_BER, 0, "t3_ber_cleared");
      expect_now(S_STAT, 0, "t3_status_252");
      send_to(2'b01, 253);
      expect_now(S_STAT, 1, "t3_status_back");
      drain();

      // 15 invalid headers spread across the 127..252 window (cycles 130,138,..,242).
      reset_dut();
      for (int j = 0; j < 15; j++) begin
         send_to(2'b01, 129 + 8 * j);
         if (j == 14) expect_now(S_BER, 0, "t6_ber_241");
         send_to(2'b00, 130 + 8 * j);
      end
      expect_now(S_BER, 1, "t6_ber_242");
      expect_now(S_LOCK, 1, "t6_lock_242");
      expect_now(S_INV, 7, "t6_inv_242");
      send_to(2'b01, 243);
      expect_now(S_STAT, 0, "t6_status_243");
      send_to(2'b01, 377);
      expect_now(S_BER, 1, "t6_ber_377");
      send_to(2'b01, 378);
      expect_now(S_BER, 0, "t6_ber_378");
      expect_now(S_STAT, 0, "t6_status_378");
      send_to(2'b01, 379);
      expect_now(S_STAT, 1, "t6_status_379");
      expect_now(S_LOCK, 1, "t6_lock_379");
      drain();

      // Locked, 16th invalid drops lock; hold-off covers 81..89; invalid after 7 counted headers slips again.
      reset_dut();
      send_to(2'b01, 64);
      send_to(2'b00, 79);
      expect_now(S_LOCK, 1, "t4_lock_79");
      expect_now(S_INV, 15, "t4_inv_79");
      send_to(2'b00, 80);
      expect_now(S_LOCK, 0, "t4_lock_lost");
      expect_now(S_SLIP, 1, "t4_slip_80");
      expect_now(S_INV,  0, "t4_inv_80");
      send_to(2'b01, 81);
      expect_now(S_SLIP, 0, "t4_slip_81");
      send_to(2'b01, 96);
      expect_now(S_LOCK, 0, "t5_lock_96");
      expect_now(S_SLIP, 0, "t5_slip_96");
      send_to(2'b00, 97);
      expect_now(S_SLIP, 1, "t5_reslip_97");
      expect_now(S_LOCK, 0, "t5_lock_97");
      send_to(2'b01, 98);
      expect_now(S_SLIP, 0, "t5_slip_98");
      send_to(2'b01, 169);
      expect_now(S_LOCK, 0, "t4_relock_169");
      send_to(2'b01, 170);
      expect_now(S_LOCK, 1, "t4_relock_170");
      expect_now(S_BER,  1, "t4_ber_170");
      send_to(2'b01, 171);
      expect_now(S_STAT, 0, "t4_status_171");
      drain();

      // Unlocked: 63 valid then invalid slips; invalids in the hold-off are ignored; never locks.
      reset_dut();
      send_to(2'b01, 63);
      send_to(2'b00, 64);
      expect_now(S_SLIP, 1, "t2_slip_64");
      expect_now(S_LOCK, 0, "t2_lock_64");
      send_to(2'b00, 65);
      expect_now(S_SLIP, 0, "t2_slip_65");
      send_to(2'b00, 73);
      expect_now(S_SLIP, 0, "t2_holdoff_73");
      send_to(2'b00, 74);
      expect_now(S_SLIP, 1, "t2_slip_74");
      expect_now(S_INV,  0, "t2_inv_74");
      send_to(2'b00, 83);
      expect_now(S_SLIP, 0, "t2_holdoff_83");
      send_to(2'b01, 146);
      expect_now(S_LOCK, 0, "t2_nolock_146");
      send_to(2'b00, 147);
      expect_now(S_SLIP, 1, "t2_slip_147");
      expect_now(S_LOCK, 0, "t2_lock_147");
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
